// File: rtl/fetch_controller_if.sv
// Fetch controller bus bundle: instruction-memory port, decode-side
// valid/ready delivery, redirect/halt control and status outputs.
interface fetch_controller_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      imem_addr;
    logic [31:0]      imem_data;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_inst;
    logic [31:0]      out_pc;
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic             halt;
    logic             fault;
    logic [3:0]       fifo_count;
    logic [CNT_W-1:0] delivered;

    // The fetch controller drives the memory address, delivery and status
    modport master (
        output imem_addr, out_valid, out_inst, out_pc, fault, fifo_count, delivered,
        input  imem_data, out_ready, redirect, redirect_pc, halt
    );

    // Memory, decode and the branch unit see the opposite directions
    modport slave (
        input  imem_addr, out_valid, out_inst, out_pc, fault, fifo_count, delivered,
        output imem_data, out_ready, redirect, redirect_pc, halt
    );
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, reads the combinational
// InstructionMemory one word per cycle, buffers {inst, pc} pairs in a small
// in-order FIFO and hands them to decode over valid/ready. Redirects flush
// the buffer; a misaligned redirect target latches a sticky fault that stops
// fetching until reset.
module fetch_controller #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2,
    parameter int          CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    fetch_controller_if.master  io_fetch
);

    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    logic [31:0]      r_pc;
    logic [31:0]      r_data [DEPTH];
    logic [31:0]      r_addr [DEPTH];
    logic [3:0]       r_count;
    logic             r_fault;
    logic [CNT_W-1:0] r_delivered;

    logic             w_pop;
    logic             w_fetch;
    logic [3:0]       w_nextCount;
    logic [31:0]      w_nextData [DEPTH];
    logic [31:0]      w_nextAddr [DEPTH];
    int               w_tail;

    // Handshake and fetch decisions; a redirect cycle never pops or pushes
    always_comb begin
        w_pop       = (r_count != 4'd0) & io_fetch.out_ready & ~io_fetch.redirect;
        w_fetch     = ~io_fetch.redirect & ~io_fetch.halt & ~r_fault &
                      ((r_count < DEPTH_C) | w_pop);
        w_nextCount = r_count + {3'b000, w_fetch} - {3'b000, w_pop};
    end

    // Entry 0 is always the head; a pop shifts live entries down, stale slots keep old values so the head holds when the buffer empties
    always_comb begin
        w_nextData = r_data;
        w_nextAddr = r_addr;
        w_tail     = int'(r_count);
        if (w_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (i + 1 < w_tail) begin
                    w_nextData[i] = r_data[i+1];
                    w_nextAddr[i] = r_addr[i+1];
                end
            end
            w_tail = w_tail - 1;
        end
        if (w_fetch) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i == w_tail) begin
                    w_nextData[i] = io_fetch.imem_data;
                    w_nextAddr[i] = r_pc;
                end
            end
        end
    end

    // PC, buffer, fault and delivery counter; redirect overrides fetch and pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_data      <= '{default: '0};
            r_addr      <= '{default: '0};
            r_count     <= 4'd0;
            r_fault     <= 1'b0;
            r_delivered <= '0;
        end else if (io_fetch.redirect) begin
            r_count <= 4'd0;
            if (io_fetch.redirect_pc[1:0] == 2'b00) begin
                r_pc <= io_fetch.redirect_pc;
            end else begin
                r_fault <= 1'b1;
            end
        end else begin
            r_data  <= w_nextData;
            r_addr  <= w_nextAddr;
            r_count <= w_nextCount;
            if (w_fetch) begin
                r_pc <= r_pc + 32'd4;
            end
            if (w_pop) begin
                r_delivered <= r_delivered + CNT_W'(1);
            end
        end
    end

    assign io_fetch.imem_addr  = r_pc;
    assign io_fetch.out_valid  = (r_count != 4'd0);
    assign io_fetch.out_inst   = r_data[0];
    assign io_fetch.out_pc     = r_addr[0];
    assign io_fetch.fault      = r_fault;
    assign io_fetch.fifo_count = r_count;
    assign io_fetch.delivered  = r_delivered;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed scenarios followed by random
// ready/redirect/halt traffic. A queue-based reference model predicts the
// fetch stream; a separate monitor compares every presented head and status
// output against it.
module tb_fetch_controller;

    localparam int          DEPTH    = 2;
    localparam int          CNT_W    = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fetch_controller_if #(.CNT_W(CNT_W)) fif ();

    fetch_controller #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH),
        .CNT_W    (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .io_fetch (fif.master)
    );

    // Free-running clock: rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    // Instruction memory contents: 0x8C220000 at 0, 0x8C230001 at 4, distinct per word
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return 32'h8C22_0000 + (a >> 2) * 32'h0001_0001;
    endfunction

    assign fif.imem_data = memWord(fif.imem_addr);

    entry_t           expQ [$];
    logic [31:0]      mPc;
    logic             mFault;
    logic [CNT_W-1:0] mDel;
    bit               cycPop;
    int               cycSize;
    int               compared   = 0;
    int               mismatched = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic resetModel();
        expQ.delete();
        mPc    = RESET_PC;
        mFault = 1'b0;
        mDel   = '0;
    endtask

    // Monitor: compare presented head and status, retire the head on a real transfer
    always @(negedge clk) begin
        #2;
        cycPop  = 1'b0;
        cycSize = expQ.size();
        if (!rst) begin
            checkOutput("out_valid", 64'(fif.out_valid), 64'(expQ.size() != 0));
            if (expQ.size() != 0) begin
                checkOutput("out_inst", 64'(fif.out_inst), 64'(expQ[0].inst));
                checkOutput("out_pc", 64'(fif.out_pc), 64'(expQ[0].pc));
            end
            checkOutput("fifo_count", 64'(fif.fifo_count), 64'(cycSize));
            checkOutput("imem_addr", 64'(fif.imem_addr), 64'(mPc));
            checkOutput("fault", 64'(fif.fault), 64'(mFault));
            checkOutput("delivered", 64'(fif.delivered), 64'(mDel));
            if (expQ.size() != 0 && fif.out_ready && !fif.redirect) begin
                cycPop = 1'b1;
                void'(expQ.pop_front());
                mDel = mDel + CNT_W'(1);
            end
        end
    end

    // Reference model: decide what the coming clock edge fetches
    always @(negedge clk) begin
        #3;
        if (!rst) begin
            if (fif.redirect) begin
                expQ.delete();
                if (fif.redirect_pc[1:0] == 2'b00) mPc = fif.redirect_pc;
                else                               mFault = 1'b1;
            end else if (!fif.halt && !mFault && (cycSize < DEPTH || cycPop)) begin
                expQ.push_back('{inst: memWord(mPc), pc: mPc});
                mPc = mPc + 32'd4;
            end
        end
    end

    task automatic applyStimulus(input bit rdy, input bit rd, input logic [31:0] rpc, input bit hl);
        @(negedge clk);
        fif.out_ready   = rdy;
        fif.redirect    = rd;
        fif.redirect_pc = rpc;
        fif.halt        = hl;
    endtask

    // Assert reset between clock edges, check its immediate effect, release on a falling edge
    task automatic doReset();
        @(negedge clk);
        #7;
        rst = 1'b1;
        resetModel();
        #1;
        checkOutput("rst_valid", 64'(fif.out_valid), 64'(0));
        checkOutput("rst_count", 64'(fif.fifo_count), 64'(0));
        checkOutput("rst_addr", 64'(fif.imem_addr), 64'(RESET_PC));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic setIdle(input bit rdy);
        fif.out_ready   = rdy;
        fif.redirect    = 1'b0;
        fif.redirect_pc = 32'h0;
        fif.halt        = 1'b0;
    endtask

    initial begin
        logic [31:0] rpc;
        int          r;
        resetModel();
        setIdle(1'b1);

        // Two words delivered back to back straight out of reset
        doReset();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        #1;
        checkOutput("t1_inst0", 64'(fif.out_inst), 64'h8C22_0000);
        checkOutput("t1_pc0", 64'(fif.out_pc), 64'h0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        #1;
        checkOutput("t1_inst1", 64'(fif.out_inst), 64'h8C23_0001);
        checkOutput("t1_pc1", 64'(fif.out_pc), 64'h4);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        #1;
        checkOutput("t1_delivered", 64'(fif.delivered), 64'd2);

        // Back-pressure fills the buffer, then it streams without a bubble
        setIdle(1'b0);
        doReset();
        for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        checkOutput("t2_full", 64'(fif.fifo_count), 64'(DEPTH));
        checkOutput("t2_pc", 64'(fif.imem_addr), 64'h8);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
            #1;
            checkOutput("t2_valid", 64'(fif.out_valid), 64'd1);
            checkOutput("t2_pc_seq", 64'(fif.out_pc), 64'(4 * k));
        end

        // Aligned redirect flushes a full buffer without counting a transfer
        applyStimulus(1'b1, 1'b1, 32'h20, 1'b0);
        #1;
        checkOutput("t3_pre_count", 64'(fif.fifo_count), 64'd2);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        #1;
        checkOutput("t3_flush", 64'(fif.fifo_count), 64'd0);
        checkOutput("t3_delivered", 64'(fif.delivered), 64'd4);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        #1;
        checkOutput("t3_target", 64'(fif.out_pc), 64'h20);

        // Misaligned redirect: sticky fault, pc frozen, nothing fetched afterwards
        applyStimulus(1'b1, 1'b1, 32'h22, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        #1;
        checkOutput("t4_fault", 64'(fif.fault), 64'd1);
        checkOutput("t4_pc", 64'(fif.imem_addr), 64'h28);
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        #1;
        checkOutput("t4_no_push", 64'(fif.fifo_count), 64'd0);
        checkOutput("t4_pc_held", 64'(fif.imem_addr), 64'h28);
        applyStimulus(1'b1, 1'b1, 32'h40, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        #1;
        checkOutput("t4_fault_sticky", 64'(fif.fault), 64'd1);
        checkOutput("t4_redirect_pc", 64'(fif.imem_addr), 64'h40);

        // Halt freezes the pc while the buffer drains, then resumes at the same pc
        setIdle(1'b1);
        doReset();
        for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        #1;
        checkOutput("t5_drained", 64'(fif.fifo_count), 64'd0);
        checkOutput("t5_frozen", 64'(fif.imem_addr), 64'h14);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        #1;
        checkOutput("t5_resume", 64'(fif.out_pc), 64'h14);

        // Reset in the middle of a stream (immediate checks live in doReset)
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        doReset();

        // Random traffic against the reference model
        for (int c = 0; c < 1500; c++) begin
            if (c % 250 == 249) begin
                doReset();
            end else begin
                r = $urandom_range(0, 9);
                if (r == 0)      rpc = ($urandom() & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
                else if (r == 1) rpc = 32'hFFFF_FFF8;
                else             rpc = 32'($urandom_range(0, 1023)) << 2;
                applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 15) == 0, rpc,
                              $urandom_range(0, 5) == 0);
            end
        end
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        #4;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
